// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for the SLC-3 MAR/MDR interface. Runs
//            single-word read/write requests on an external asynchronous
//            16-bit SRAM with a fixed number of wait states, returns
//            registered read data and pulses a one-cycle completion.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int WAIT_STATES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  // request side (MAR / MDR / control FSM)
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [15:0]        mem_address,
  input  logic [15:0]        mem_wdata,
  output logic [15:0]        mem_rdata,
  output logic               mem_resp,
  output logic               busy,
  // SRAM side
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq_in,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter reload value: the access phase lasts WAIT_STATES+1 cycles,
  // ending in the cycle where the counter reads zero.
  localparam logic [3:0] c_wait_load = 4'(WAIT_STATES);
  localparam int         c_pad_w     = SRAM_AW - 16;

  // Control state
  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_count;
  logic [3:0]  w_count_nxt;
  logic [15:0] r_addr;
  logic [15:0] w_addr_nxt;
  logic [15:0] r_wdata;
  logic [15:0] w_wdata_nxt;
  logic        r_is_write;
  logic        w_is_write_nxt;

  // Next values of the registered outputs
  logic [15:0]        w_rdata_nxt;
  logic               w_resp_nxt;
  logic               w_busy_nxt;
  logic [SRAM_AW-1:0] w_sram_addr_nxt;
  logic [15:0]        w_dq_out_nxt;
  logic               w_dq_oe_nxt;
  logic               w_ce_n_nxt;
  logic               w_oe_n_nxt;
  logic               w_we_n_nxt;
  logic               w_bytes_n_nxt;

  // Next-state logic: accept a request in IDLE (read has priority), count
  // down the access phase, capture read data on the final access cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_is_write_nxt = r_is_write;
    w_rdata_nxt    = mem_rdata;

    case (r_state)
      IDLE: begin
        if (mem_read) begin
          w_addr_nxt     = mem_address;
          w_count_nxt    = c_wait_load;
          w_is_write_nxt = 1'b0;
          w_state_nxt    = READ;
        end else if (mem_write) begin
          w_addr_nxt     = mem_address;
          w_wdata_nxt    = mem_wdata;
          w_count_nxt    = c_wait_load;
          w_is_write_nxt = 1'b1;
          w_state_nxt    = WRITE;
        end
      end

      READ: begin
        if (r_count == 4'd0) begin
          w_rdata_nxt = sram_dq_in;
          w_state_nxt = RESP;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
      end

      WRITE: begin
        if (r_count == 4'd0) begin
          w_state_nxt = RESP;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
      end

      RESP: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the next state, so every output is a register that
  // already reflects the state being entered.
  always_comb begin
    w_resp_nxt      = 1'b0;
    w_busy_nxt      = 1'b0;
    w_sram_addr_nxt = '0;
    w_dq_out_nxt    = 16'h0000;
    w_dq_oe_nxt     = 1'b0;
    w_ce_n_nxt      = 1'b1;
    w_oe_n_nxt      = 1'b1;
    w_we_n_nxt      = 1'b1;
    w_bytes_n_nxt   = 1'b1;

    case (w_state_nxt)
      READ: begin
        w_busy_nxt      = 1'b1;
        w_sram_addr_nxt = {{c_pad_w{1'b0}}, w_addr_nxt};
        w_ce_n_nxt      = 1'b0;
        w_oe_n_nxt      = 1'b0;
        w_bytes_n_nxt   = 1'b0;
      end

      WRITE: begin
        w_busy_nxt      = 1'b1;
        w_sram_addr_nxt = {{c_pad_w{1'b0}}, w_addr_nxt};
        w_ce_n_nxt      = 1'b0;
        w_we_n_nxt      = 1'b0;
        w_bytes_n_nxt   = 1'b0;
        w_dq_oe_nxt     = 1'b1;
        w_dq_out_nxt    = w_wdata_nxt;
      end

      RESP: begin
        w_busy_nxt      = 1'b1;
        w_resp_nxt      = 1'b1;
        w_sram_addr_nxt = {{c_pad_w{1'b0}}, w_addr_nxt};
        // Keep driving write data one cycle past the we_n rising edge
        // to satisfy SRAM data hold time.
        w_dq_oe_nxt     = w_is_write_nxt;
        w_dq_out_nxt    = w_is_write_nxt ? w_wdata_nxt : 16'h0000;
      end

      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Control registers: state, wait counter and latched request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_addr     <= 16'h0000;
      r_wdata    <= 16'h0000;
      r_is_write <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_is_write <= w_is_write_nxt;
    end
  end

  // Output registers; reset parks the SRAM with all strobes inactive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rdata   <= 16'h0000;
      mem_resp    <= 1'b0;
      busy        <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= 16'h0000;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
    end else begin
      mem_rdata   <= w_rdata_nxt;
      mem_resp    <= w_resp_nxt;
      busy        <= w_busy_nxt;
      sram_addr   <= w_sram_addr_nxt;
      sram_dq_out <= w_dq_out_nxt;
      sram_dq_oe  <= w_dq_oe_nxt;
      sram_ce_n   <= w_ce_n_nxt;
      sram_oe_n   <= w_oe_n_nxt;
      sram_we_n   <= w_we_n_nxt;
      sram_ub_n   <= w_bytes_n_nxt;
      sram_lb_n   <= w_bytes_n_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Scoreboard bench for mem_responder: randomized read/write
//            traffic against a word-array reference memory, plus directed
//            reset, priority, back-to-back and zero-wait-state cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int WS = 2;
  localparam int N  = WS + 1;

  logic        clk = 1'b0;
  logic        reset_n;

  // main instance (WAIT_STATES = 2)
  logic        mem_read, mem_write, mem_resp, busy;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_in, sram_dq_out;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  // second instance (WAIT_STATES = 0)
  logic        mem_read0, mem_write0, mem_resp0, busy0;
  logic [15:0] mem_address0, mem_wdata0, mem_rdata0;
  logic [19:0] sram_addr0;
  logic [15:0] sram_dq_in0, sram_dq_out0;
  logic        sram_dq_oe0, sram_ce_n0, sram_oe_n0, sram_we_n0, sram_ub_n0, sram_lb_n0;

  mem_responder #(.WAIT_STATES(WS), .SRAM_AW(20)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  mem_responder #(.WAIT_STATES(0), .SRAM_AW(20)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read0), .mem_write(mem_write0),
    .mem_address(mem_address0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .mem_resp(mem_resp0), .busy(busy0),
    .sram_addr(sram_addr0), .sram_dq_in(sram_dq_in0), .sram_dq_out(sram_dq_out0),
    .sram_dq_oe(sram_dq_oe0), .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0),
    .sram_we_n(sram_we_n0), .sram_ub_n(sram_ub_n0), .sram_lb_n(sram_lb_n0)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cycle_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none (t=%0t)", name, $time);
  endtask

  // Power-on SRAM contents, shared by the SRAM model and the reference model.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h3000)      return 16'hBEEF;
    else if (a == 16'h0010) return 16'h1111;
    else                    return a ^ 16'h5A5A;
  endfunction

  // ---------------- SRAM model (main instance) ----------------
  logic [15:0] sram_mem [0:65535];
  bit          sram_vld [0:65535];

  initial forever begin
    @(posedge clk);
    if (!sram_ce_n && !sram_we_n && sram_dq_oe && sram_addr[19:16] == 4'h0) begin
      sram_mem[sram_addr[15:0]] = sram_dq_out;
      sram_vld[sram_addr[15:0]] = 1'b1;
    end
  end

  initial begin
    sram_dq_in = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (!sram_ce_n && !sram_oe_n && sram_addr[19:16] == 4'h0)
        sram_dq_in = sram_vld[sram_addr[15:0]] ? sram_mem[sram_addr[15:0]]
                                               : init_val(sram_addr[15:0]);
      else
        sram_dq_in = 16'hDEAD;
    end
  end

  // Zero-wait instance: read-only SRAM with data derived from the address.
  assign sram_dq_in0 = (!sram_ce_n0 && !sram_oe_n0) ? (sram_addr0[15:0] ^ 16'hC3C3) : 16'h0000;

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit          is_read;
    logic [15:0] addr;
    logic [15:0] data;
    int unsigned cyc;
  } txn_t;

  txn_t        q[$];
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  initial forever begin
    @(posedge clk);
    cycle_cnt++;
  end

  // Monitor: strobe accounting, address/data checks, response pop.
  initial begin : monitor
    txn_t        t;
    logic [15:0] exp_rdata;
    int          ce_cnt, oe_cnt, we_cnt, dqoe_cnt;
    exp_rdata = 16'h0000;
    ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        q.delete();
        exp_rdata = 16'h0000;
        ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
      end else begin
        if (!sram_ce_n)  ce_cnt++;
        if (!sram_oe_n)  oe_cnt++;
        if (!sram_we_n)  we_cnt++;
        if (sram_dq_oe)  dqoe_cnt++;
        if (!sram_ce_n || sram_dq_oe) begin
          if (q.size() == 0) fail_now("strobe_without_request");
          else begin
            if (!sram_ce_n) chk("sram_addr", {12'h0, sram_addr}, {16'h0, 4'h0, q[0].addr});
            if (sram_dq_oe) chk("sram_dq_out", {16'h0, sram_dq_out}, {16'h0, q[0].data});
          end
        end
        if (mem_resp) begin
          if (q.size() == 0) fail_now("spurious_mem_resp");
          else begin
            t = q.pop_front();
            chk("resp_latency", cycle_cnt - t.cyc, N + 1);
            chk("busy_in_resp", {31'h0, busy}, 1);
            chk("ce_low_cycles", ce_cnt, N);
            if (t.is_read) begin
              exp_rdata = t.data;
              chk("oe_low_cycles_rd", oe_cnt, N);
              chk("we_low_cycles_rd", we_cnt, 0);
              chk("dq_oe_cycles_rd", dqoe_cnt, 0);
            end else begin
              chk("oe_low_cycles_wr", oe_cnt, 0);
              chk("we_low_cycles_wr", we_cnt, N);
              chk("dq_oe_cycles_wr", dqoe_cnt, N + 1);
            end
          end
          ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
        end
        chk("mem_rdata", {16'h0, mem_rdata}, {16'h0, exp_rdata});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called one step after a rising edge; returns one step after the edge on
  // which mem_resp was sampled, with the request dropped.
  task automatic run_txn(input bit rd, input bit wr, input logic [15:0] a,
                         input logic [15:0] d, input bit wiggle);
    txn_t t;
    bit   got;
    mem_read    = rd;
    mem_write   = wr;
    mem_address = a;
    mem_wdata   = d;
    t.is_read = rd;
    t.addr    = a;
    t.cyc     = cycle_cnt;
    if (rd) t.data = ref_rd(a);
    else begin
      t.data = d;
      ref_mem[int'(a)] = d;
    end
    q.push_back(t);
    got = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (mem_resp) got = 1;
      @(posedge clk);
      #1;
      if (!got && wiggle) begin
        mem_address = 16'($urandom);
        mem_wdata   = 16'($urandom);
        mem_read    = 1'($urandom);
        mem_write   = 1'($urandom);
      end
    end
    if (!got) fail_now("resp_timeout");
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 31));
    return 16'hFFE0 + 16'($urandom_range(0, 31));
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          k;
    int unsigned sel;
    bit          rd, wr;
    reset_n      = 1'b0;
    mem_read     = 1'b1;
    mem_write    = 1'b0;
    mem_address  = 16'h3000;
    mem_wdata    = 16'h0000;
    mem_read0    = 1'b0;
    mem_write0   = 1'b0;
    mem_address0 = 16'h0000;
    mem_wdata0   = 16'h0000;

    // reset held with a read request pending
    repeat (3) @(negedge clk);
    chk("rst_ce_n", {31'h0, sram_ce_n}, 1);
    chk("rst_oe_n", {31'h0, sram_oe_n}, 1);
    chk("rst_we_n", {31'h0, sram_we_n}, 1);
    chk("rst_ub_lb_n", {30'h0, sram_ub_n, sram_lb_n}, 3);
    chk("rst_mem_resp", {31'h0, mem_resp}, 0);
    chk("rst_mem_rdata", {16'h0, mem_rdata}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_dq_oe", {31'h0, sram_dq_oe}, 0);
    chk("rst_sram_addr", {12'h0, sram_addr}, 0);
    mem_read = 1'b0;
    #2 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", {31'h0, busy}, 0);
      chk("idle_ce_n", {31'h0, sram_ce_n}, 1);
    end
    @(posedge clk);
    #1;

    // directed cases
    run_txn(1, 0, 16'h3000, 16'h0000, 0);
    idle(2);
    run_txn(0, 1, 16'h1234, 16'hA5A5, 0);
    idle(1);
    run_txn(1, 0, 16'h1234, 16'h0000, 0);
    run_txn(1, 1, 16'h0010, 16'h2222, 0);
    run_txn(1, 0, 16'h0010, 16'h0000, 0);
    run_txn(0, 1, 16'h0050, 16'h0001, 0);
    run_txn(1, 0, 16'h0050, 16'h0000, 0);
    run_txn(0, 1, 16'hFFFF, 16'h7E57, 0);
    run_txn(1, 0, 16'hFFFF, 16'h0000, 1);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel <= 3) || (sel >= 8);
      wr  = (sel >= 4) && (sel <= 8);
      run_txn(rd, wr, rand_addr(), 16'($urandom), 1'($urandom));
      idle(int'($urandom_range(0, 3)));
    end

    // reset in the second WRITE cycle
    begin
      txn_t t;
      mem_write   = 1'b1;
      mem_address = 16'h7777;
      mem_wdata   = 16'h5555;
      t.is_read = 0; t.addr = 16'h7777; t.data = 16'h5555; t.cyc = cycle_cnt;
      q.push_back(t);
    end
    idle(2);
    chk("we_n_before_abort", {31'h0, sram_we_n}, 0);
    reset_n   = 1'b0;
    mem_write = 1'b0;
    #1;
    chk("abort_we_n", {31'h0, sram_we_n}, 1);
    chk("abort_dq_oe", {31'h0, sram_dq_oe}, 0);
    chk("abort_ce_n", {31'h0, sram_ce_n}, 1);
    chk("abort_busy", {31'h0, busy}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", {31'h0, mem_resp}, 0);
    end
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn(1, 0, 16'h1234, 16'h0000, 0);

    // zero-wait-state read: response two cycles after the request
    mem_read0    = 1'b1;
    mem_address0 = 16'h0042;
    @(negedge clk);
    chk("ws0_k_resp", {31'h0, mem_resp0}, 0);
    @(negedge clk);
    chk("ws0_k1_ce_n", {31'h0, sram_ce_n0}, 0);
    chk("ws0_k1_resp", {31'h0, mem_resp0}, 0);
    @(negedge clk);
    chk("ws0_k2_resp", {31'h0, mem_resp0}, 1);
    chk("ws0_rdata", {16'h0, mem_rdata0}, {16'h0, 16'h0042 ^ 16'hC3C3});
    @(posedge clk);
    #1;
    mem_read0 = 1'b0;
    @(negedge clk);
    chk("ws0_k3_resp", {31'h0, mem_resp0}, 0);
    chk("ws0_k3_busy", {31'h0, busy0}, 0);

    idle(3);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
